serial_match_checker: RTL and testbench

- Sequential consumer placed directly downstream of the 2-input XNOR gate.
- Takes the gate's per-bit equality output (1 = bits a and b equal) as a serial stream, one bit per accepted cycle.
- Over a frame of FRAME_LEN bits it counts mismatches and records the index of the first mismatch.
- At frame end it reports a single match/no-match verdict with a one-cycle done pulse.

---
 rtl/serial_match_checker.sv | 98 +++++++++
 tb/tb_serial_match_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_match_checker.sv
// serial_match_checker: consumes the per-bit equality stream from an XNOR
// gate and, over a frame of FRAME_LEN bits, counts mismatches, records the
// index of the first one and reports a match verdict with a one-cycle done.
// Optional build macro: SERIAL_MATCH_EARLY_EXIT_EN -- the first mismatch
// ends the frame immediately instead of consuming all FRAME_LEN bits.
module serial_match_checker #(
  parameter int FRAME_LEN = 8,
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             eq_valid,
  input  logic             eq_bit,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] NO_ERR   = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_idx;
  logic [CNT_W-1:0] err_nxt;
  logic             consume;
  logic             mism;
  logic             last_bit;
  logic             frame_end;
  logic             start_ok;

  // Decode what the current cycle does to the frame: consume, mismatch, end.
  always_comb begin
    consume  = (state == ST_RUN) && eq_valid;
    mism     = consume && !eq_bit;
    last_bit = consume && (bit_idx == LAST_IDX);
`ifdef SERIAL_MATCH_EARLY_EXIT_EN
    frame_end = last_bit || mism;
`else
    frame_end = last_bit;
`endif
    start_ok = start && (state != ST_RUN);
    err_nxt  = mism ? (err_count + CNT_W'(1)) : err_count;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (frame_end) state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Frame bookkeeping: cleared on an accepted start, held otherwise so the
  // last verdict stays readable in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx       <= '0;
      err_count     <= '0;
      first_err_idx <= NO_ERR;
      match         <= 1'b0;
    end else if (start_ok) begin
      bit_idx       <= '0;
      err_count     <= '0;
      first_err_idx <= NO_ERR;
      match         <= 1'b0;
    end else if (consume) begin
      bit_idx   <= frame_end ? '0 : (bit_idx + CNT_W'(1));
      err_count <= err_nxt;
      if (mism && (err_count == '0))
        first_err_idx <= bit_idx;
      if (frame_end)
        match <= (err_nxt == '0);
    end
  end

endmodule

// File: tb/tb_serial_match_checker.sv
// Directed testbench for serial_match_checker (FRAME_LEN = 8, CNT_W = 4).
// Expectations follow SERIAL_MATCH_EARLY_EXIT_EN when it is defined.
module tb_serial_match_checker;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             eq_valid;
  logic             eq_bit_tb;
  logic             use_gate;
  logic             a;
  logic             b;
  wire              gate_c;
  logic             eq_bit;
  logic             busy;
  logic             done;
  logic             match;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int t0;
  int dc0;
  logic saw_done;

  xnor u_xnor (gate_c, a, b);
  assign eq_bit = use_gate ? gate_c : eq_bit_tb;

  serial_match_checker #(.FRAME_LEN(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .eq_valid      (eq_valid),
    .eq_bit        (eq_bit),
    .busy          (busy),
    .done          (done),
    .match         (match),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0  = cyc;
    dc0 = done_cnt;
  endtask

  task automatic send_bit(input logic v);
    eq_valid  = 1'b1;
    eq_bit_tb = v;
    tick();
    eq_valid  = 1'b0;
  endtask

  task automatic send_pair(input logic av, input logic bv);
    use_gate = 1'b1;
    a = av;
    b = bv;
    eq_valid = 1'b1;
    tick();
    eq_valid = 1'b0;
    use_gate = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; eq_valid = 1'b0; eq_bit_tb = 1'b1;
    use_gate = 1'b0; a = 1'b0; b = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_idx, 4'hF);
    rst_n = 1'b1;
    tick();

    // Reset mid-frame: 3 bits consumed, then a 1 ns async reset pulse.
    do_start();
    chk("mid_busy_run", busy, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("mid_err_before", err_count, 1);
    chk("mid_first_before", first_err_idx, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", busy, 0);
    chk("mid_err_rst", err_count, 0);
    chk("mid_first_rst", first_err_idx, 4'hF);
    rst_n = 1'b1;
    dc0 = done_cnt;
    for (int i = 0; i < 12; i++) begin
      eq_valid = 1'b1; eq_bit_tb = 1'b1;
      tick();
    end
    eq_valid = 1'b0;
    chk("mid_no_done", done_cnt - dc0, 0);
    chk("mid_idle_busy", busy, 0);

    // All-equal frame; start held during a RUN bit must be ignored.
    do_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    start = 1'b1;
    send_bit(1'b1);
    start = 1'b0;
    chk("eq_busy_mid", busy, 1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("eq_done_early", done, 0);
    send_bit(1'b1);
    chk("eq_done", done, 1);
    chk("eq_busy_done", busy, 0);
    chk("eq_match", match, 1);
    chk("eq_err", err_count, 0);
    chk("eq_first", first_err_idx, 4'hF);
    tick();
    chk("eq_done_cnt", done_cnt - dc0, 1);
    chk("eq_latency", done_cyc - t0, 8);
    chk("eq_done_pulse", done, 0);
    chk("eq_retain_match", match, 1);

    // Mismatches at indices 2 and 5 with a 2-cycle gap between bits 3 and 4.
    do_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    tick(); tick();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
`ifndef SERIAL_MATCH_EARLY_EXIT_EN
    chk("gap_done", done, 1);
`endif
    tick();
    chk("gap_done_cnt", done_cnt - dc0, 1);
`ifdef SERIAL_MATCH_EARLY_EXIT_EN
    chk("gap_latency", done_cyc - t0, 3);
    chk("gap_err", err_count, 1);
`else
    chk("gap_latency", done_cyc - t0, 10);
    chk("gap_err", err_count, 2);
`endif
    chk("gap_first", first_err_idx, 2);
    chk("gap_match", match, 0);

    // Back-to-back: mismatch on the last bit, restart from DONE.
    do_start();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    send_bit(1'b0);
    chk("b2b_done", done, 1);
    chk("b2b_err1", err_count, 1);
    chk("b2b_first1", first_err_idx, 7);
    chk("b2b_match1", match, 0);
    start = 1'b1; eq_valid = 1'b1; eq_bit_tb = 1'b0;
    tick();
    start = 1'b0; eq_valid = 1'b0;
    t0 = cyc; dc0 = done_cnt;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_err_clr", err_count, 0);
    chk("b2b_first_clr", first_err_idx, 4'hF);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    chk("b2b_done2", done, 1);
    chk("b2b_match2", match, 1);
    chk("b2b_err2", err_count, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      eq_valid = 1'b1; eq_bit_tb = 1'b0;
      tick();
    end
    eq_valid = 1'b0;
    chk("idle_ignore_err", err_count, 0);
    chk("idle_ignore_busy", busy, 0);
    chk("idle_ignore_match", match, 1);
    chk("b2b_done_cnt", done_cnt - dc0, 1);

    // Mismatch at index 1 only.
    do_start();
    send_bit(1'b1); send_bit(1'b0);
`ifdef SERIAL_MATCH_EARLY_EXIT_EN
    chk("m1_done", done, 1);
    chk("m1_err_now", err_count, 1);
`else
    chk("m1_done", done, 0);
    chk("m1_busy", busy, 1);
`endif
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    tick();
    chk("m1_done_cnt", done_cnt - dc0, 1);
`ifdef SERIAL_MATCH_EARLY_EXIT_EN
    chk("m1_latency", done_cyc - t0, 2);
`else
    chk("m1_latency", done_cyc - t0, 8);
`endif
    chk("m1_err", err_count, 1);
    chk("m1_first", first_err_idx, 1);
    chk("m1_match", match, 0);

    // End-to-end through the XNOR gate.
    do_start();
    send_pair(1'b0, 1'b0); send_pair(1'b1, 1'b0);
    send_pair(1'b0, 1'b1); send_pair(1'b1, 1'b1);
    send_pair(1'b0, 1'b0); send_pair(1'b0, 1'b0);
    send_pair(1'b1, 1'b1); send_pair(1'b1, 1'b1);
    tick();
    chk("xnor_done_cnt", done_cnt - dc0, 1);
`ifdef SERIAL_MATCH_EARLY_EXIT_EN
    chk("xnor_err", err_count, 1);
    chk("xnor_latency", done_cyc - t0, 2);
`else
    chk("xnor_err", err_count, 2);
    chk("xnor_latency", done_cyc - t0, 8);
`endif
    chk("xnor_first", first_err_idx, 1);
    chk("xnor_match", match, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
